// File: rtl/dsc_mul_accum.sv
// ---------------------------------------------------------------------------
// dsc_mul_accum
//   Accumulates NUM_TERMS consecutive unsigned products from dsc_serial_mul
//   into one dot-product result and offers it on a valid/ready output. The
//   block drives the multiplier enable itself, so the multiplier is paused
//   while a finished result waits for the consumer.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request a new dot product (accepted in IDLE, or in HOLD
//                together with sum_ready)
//   prod_in    : product from the multiplier, valid when prod_done=1
//   prod_done  : one-cycle pulse per product
//   mul_en     : registered enable to the multiplier
//   sum_out    : accumulated result, stable while sum_valid=1
//   sum_valid  : result available
//   sum_ready  : consumer accepts the result
//   term_cnt   : products accumulated in the current operation
//   busy       : high while accumulating
//   err_drop   : sticky, a product arrived while not accumulating
// ---------------------------------------------------------------------------
module dsc_mul_accum #(
    parameter  int PROD_WIDTH = 10,
    parameter  int NUM_TERMS  = 4,
    localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(NUM_TERMS + 1),
    localparam int CNT_WIDTH  = $clog2(NUM_TERMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PROD_WIDTH-1:0] prod_in,
    input  logic                  prod_done,
    output logic                  mul_en,
    output logic [ACC_WIDTH-1:0]  sum_out,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic [CNT_WIDTH-1:0]  term_cnt,
    output logic                  busy,
    output logic                  err_drop
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_TERMS);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   mul_en_q, mul_en_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;

    // ACC_WIDTH leaves enough headroom that this sum never wraps.
    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){1'b0}}, prod_in};
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        mul_en_d = mul_en_q;
        valid_d  = valid_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    mul_en_d = 1'b1;
                    state_d  = S_ACCUM;
                end
                // A product arriving here is dropped; the flag wins over the
                // clear from a same-cycle start so the loss is never hidden.
                if (prod_done) begin
                    err_d = 1'b1;
                end
            end

            S_ACCUM: begin
                if (prod_done) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        sum_d    = acc_sum;
                        valid_d  = 1'b1;
                        mul_en_d = 1'b0;
                        cnt_d    = FULL_CNT;
                        state_d  = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (sum_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        // Back-to-back: the enable was low for the whole HOLD
                        // stay, so the multiplier still sees a restart.
                        acc_d    = '0;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        mul_en_d = 1'b1;
                        state_d  = S_ACCUM;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
                if (prod_done) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                mul_en_d = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            mul_en_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            mul_en_q <= mul_en_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign mul_en    = mul_en_q;
    assign sum_out   = sum_q;
    assign sum_valid = valid_q;
    assign term_cnt  = cnt_q;
    assign busy      = (state_q == S_ACCUM);
    assign err_drop  = err_q;

endmodule

// File: tb/tb_dsc_mul_accum.sv
// ---------------------------------------------------------------------------
// tb_dsc_mul_accum
//   Self-checking bench for dsc_mul_accum. A default build (PROD_WIDTH=10,
//   NUM_TERMS=4) is compared every cycle against a queue-based reference
//   model; a NUM_TERMS=1 build is exercised by a short directed sequence.
// ---------------------------------------------------------------------------
module tb_dsc_mul_accum;

    localparam int PW = 10;
    localparam int NT = 4;
    localparam int AW = PW + $clog2(NT + 1);
    localparam int CW = $clog2(NT + 1);
    localparam int AW1 = PW + $clog2(2);
    localparam int CW1 = $clog2(2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] prod_in;
    logic          prod_done;
    logic          sum_ready;
    logic          mul_en;
    logic [AW-1:0] sum_out;
    logic          sum_valid;
    logic [CW-1:0] term_cnt;
    logic          busy;
    logic          err_drop;

    logic           start1;
    logic [PW-1:0]  prod_in1;
    logic           prod_done1;
    logic           sum_ready1;
    logic           mul_en1;
    logic [AW1-1:0] sum_out1;
    logic           sum_valid1;
    logic [CW1-1:0] term_cnt1;
    logic           busy1;
    logic           err_drop1;

    always #5 clk = ~clk;

    dsc_mul_accum #(.PROD_WIDTH(PW), .NUM_TERMS(NT)) dut (
        .clk(clk), .rst(rst), .start(start), .prod_in(prod_in),
        .prod_done(prod_done), .mul_en(mul_en), .sum_out(sum_out),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .term_cnt(term_cnt),
        .busy(busy), .err_drop(err_drop)
    );

    dsc_mul_accum #(.PROD_WIDTH(PW), .NUM_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .prod_in(prod_in1),
        .prod_done(prod_done1), .mul_en(mul_en1), .sum_out(sum_out1),
        .sum_valid(sum_valid1), .sum_ready(sum_ready1), .term_cnt(term_cnt1),
        .busy(busy1), .err_drop(err_drop1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation is "collecting" until NT products are queued, then
    // "holding" until the consumer takes the result.
    int unsigned terms[$];
    bit          m_collecting;
    bit          m_holding;
    bit          m_err;
    int unsigned m_sum;

    function automatic int unsigned q_total();
        int unsigned s = 0;
        foreach (terms[i]) s += terms[i];
        return s;
    endfunction

    task automatic m_reset();
        terms.delete();
        m_collecting = 0;
        m_holding    = 0;
        m_err        = 0;
        m_sum        = 0;
    endtask

    task automatic m_begin();
        terms.delete();
        m_collecting = 1;
        m_err        = 0;
    endtask

    task automatic m_step();
        if (rst) begin
            m_reset();
        end else if (m_collecting) begin
            if (prod_done) begin
                terms.push_back(int'(prod_in));
                if (terms.size() == NT) begin
                    m_sum        = q_total();
                    m_collecting = 0;
                    m_holding    = 1;
                end
            end
        end else begin
            if (m_holding) begin
                if (sum_ready) begin
                    m_holding = 0;
                    if (start) m_begin();
                end
            end else if (start) begin
                m_begin();
            end
            if (prod_done) m_err = 1;
        end
    endtask

    task automatic check_all();
        chk("sum_valid", 32'(sum_valid), 32'(m_holding));
        chk("mul_en",    32'(mul_en),    32'(m_collecting));
        chk("busy",      32'(busy),      32'(m_collecting));
        chk("term_cnt",  32'(term_cnt),  32'(terms.size()));
        chk("err_drop",  32'(err_drop),  32'(m_err));
        chk("sum_out",   32'(sum_out),   m_sum);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            prod_in = PW'($urandom);
            tick();
        end
    endtask

    task automatic put(input logic [PW-1:0] v);
        prod_in   = v;
        prod_done = 1'b1;
        tick();
        prod_done = 1'b0;
    endtask

    task automatic begin_op();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mul_en_after_start", 32'(mul_en), 32'd1);
    endtask

    task automatic feed(input logic [NT-1:0][PW-1:0] p, input int gap);
        for (int i = 0; i < NT; i++) begin
            idle(gap);
            put(p[i]);
        end
        chk("valid_after_last", 32'(sum_valid), 32'd1);
        chk("mul_en_low_in_hold", 32'(mul_en), 32'd0);
        chk("term_cnt_full", 32'(term_cnt), 32'(NT));
    endtask

    task automatic handshake();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("valid_after_hs", 32'(sum_valid), 32'd0);
    endtask

    typedef struct {
        logic [NT-1:0][PW-1:0] p;
        int                    gap;
        logic [31:0]           exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [NT-1:0][PW-1:0] pv;
        bit in_op;

        tbl[0].p = {PW'(9), PW'(7), PW'(5), PW'(3)};       tbl[0].gap = 32; tbl[0].exp = 24;
        tbl[1].p = {PW'(1023), PW'(1023), PW'(1023), PW'(1023)}; tbl[1].gap = 3; tbl[1].exp = 4092;
        tbl[2].p = {PW'(0), PW'(0), PW'(0), PW'(0)};       tbl[2].gap = 1;  tbl[2].exp = 0;
        tbl[3].p = {PW'(40), PW'(30), PW'(20), PW'(10)};   tbl[3].gap = 0;  tbl[3].exp = 100;
        tbl[4].p = {PW'(1), PW'(1023), PW'(512), PW'(511)}; tbl[4].gap = 2; tbl[4].exp = 2047;

        rst = 1'b1; start = 0; prod_in = 0; prod_done = 0; sum_ready = 0;
        start1 = 0; prod_in1 = 0; prod_done1 = 0; sum_ready1 = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("nt1_reset_valid", 32'(sum_valid1), 32'd0);
        chk("nt1_reset_sum", 32'(sum_out1), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven operations.
        for (int i = 0; i < 5; i++) begin
            begin_op();
            feed(tbl[i].p, tbl[i].gap);
            chk($sformatf("tbl%0d_sum", i), 32'(sum_out), tbl[i].exp);
            handshake();
            chk($sformatf("tbl%0d_sum_kept", i), 32'(sum_out), tbl[i].exp);
            idle(2);
        end

        // Backpressure then back-to-back restart.
        begin_op();
        feed({PW'(9), PW'(7), PW'(5), PW'(3)}, 1);
        for (int i = 0; i < 50; i++) begin
            start = 1'(i % 3 == 0);
            tick();
        end
        chk("bp_sum_stable", 32'(sum_out), 32'd24);
        chk("bp_mul_en", 32'(mul_en), 32'd0);
        sum_ready = 1'b1;
        start     = 1'b1;
        tick();
        sum_ready = 1'b0;
        start     = 1'b0;
        chk("b2b_valid", 32'(sum_valid), 32'd0);
        chk("b2b_mul_en", 32'(mul_en), 32'd1);
        chk("b2b_cnt", 32'(term_cnt), 32'd0);
        feed({PW'(1), PW'(1), PW'(1), PW'(1)}, 2);
        chk("b2b_sum", 32'(sum_out), 32'd4);
        handshake();

        // Stray product while idle.
        idle(2);
        put(PW'(100));
        chk("stray_err", 32'(err_drop), 32'd1);
        idle(3);
        begin_op();
        chk("stray_err_cleared", 32'(err_drop), 32'd0);
        feed({PW'(2), PW'(2), PW'(2), PW'(2)}, 1);
        chk("stray_sum", 32'(sum_out), 32'd8);
        // Stray product while holding a result.
        put(PW'(55));
        chk("hold_stray_err", 32'(err_drop), 32'd1);
        chk("hold_stray_sum", 32'(sum_out), 32'd8);
        handshake();

        // Reset in the middle of an operation.
        begin_op();
        idle(1); put(PW'(7));
        idle(1); put(PW'(8));
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_mul_en", 32'(mul_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(term_cnt), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        begin_op();
        feed({PW'(4), PW'(3), PW'(2), PW'(1)}, 1);
        chk("after_rst_sum", 32'(sum_out), 32'd10);
        handshake();

        // NUM_TERMS=1 build; the default build idles and stays model-checked.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("nt1_mul_en", 32'(mul_en1), 32'd1);
        chk("nt1_busy", 32'(busy1), 32'd1);
        prod_in1   = PW'(777);
        prod_done1 = 1'b1;
        tick();
        prod_done1 = 1'b0;
        chk("nt1_valid", 32'(sum_valid1), 32'd1);
        chk("nt1_sum", 32'(sum_out1), 32'd777);
        chk("nt1_cnt", 32'(term_cnt1), 32'd1);
        chk("nt1_mul_en_low", 32'(mul_en1), 32'd0);
        sum_ready1 = 1'b1;
        tick();
        sum_ready1 = 1'b0;
        chk("nt1_valid_fall", 32'(sum_valid1), 32'd0);
        chk("nt1_sum_kept", 32'(sum_out1), 32'd777);

        // Randomized operations against the model.
        in_op = 0;
        for (int op = 0; op < 30; op++) begin
            if (!in_op) begin
                if ($urandom_range(0, 3) == 0) put(PW'($urandom));
                idle($urandom_range(0, 2));
                begin_op();
            end
            for (int i = 0; i < NT; i++) pv[i] = PW'($urandom);
            feed(pv, $urandom_range(0, 4));
            for (int k = $urandom_range(0, 6); k > 0; k--) begin
                start     = 1'($urandom);
                prod_done = ($urandom_range(0, 7) == 0);
                prod_in   = PW'($urandom);
                tick();
            end
            prod_done = 1'b0;
            sum_ready = 1'b1;
            start     = 1'($urandom);
            in_op     = start;
            tick();
            sum_ready = 1'b0;
            start     = 1'b0;
        end
        if (in_op) begin
            feed({PW'(1), PW'(2), PW'(3), PW'(4)}, 0);
            handshake();
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dsc_mul_accum.md
Name: dsc_mul_accum

Overview:
- Downstream stage of dsc_serial_mul: consumes each binary product when the multiplier's done pulses.
- Sums NUM_TERMS consecutive products into one dot-product result and presents it on a valid/ready output.
- Owns the multiplier's enable, so it throttles the multiplier while a result waits unconsumed.
- Sits between the serial multiplier and the result collector in the arch_sweep datapath.

Parameters:
- PROD_WIDTH, 10: width of the multiplier product bus (bin_data_out of dsc_serial_mul).
- NUM_TERMS, 4: products accumulated per result; must be >=1.
- ACC_WIDTH, PROD_WIDTH+$clog2(NUM_TERMS+1): accumulator/result width. Localparam, not overridable.
- CNT_WIDTH, $clog2(NUM_TERMS+1): term counter width. Localparam.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new dot product; sampled in IDLE, or in HOLD when sum_ready=1.
- prod_in  in  PROD_WIDTH  product from multiplier; valid only when prod_done=1.
- prod_done  in  1  multiplier done; one-cycle pulse per product.
- mul_en  out  1  enable to multiplier; registered.
- sum_out  out  ACC_WIDTH  accumulated result; stable while sum_valid=1.
- sum_valid  out  1  result available.
- sum_ready  in  1  consumer accepts result.
- term_cnt  out  CNT_WIDTH  products accumulated so far in current operation.
- busy  out  1  high in ACCUM.
- err_drop  out  1  sticky flag: prod_done seen outside ACCUM.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; acc, sum_out, term_cnt = 0; mul_en, sum_valid, busy, err_drop = 0. Partial sums are discarded. No output glitches to nonzero during reset.
- States:
  - IDLE: mul_en=0. start=1 -> acc<=0, term_cnt<=0, err_drop<=0, mul_en<=1, go to ACCUM.
  - ACCUM: busy=1, mul_en=1.
    - On prod_done: acc <= acc + zero-extended prod_in; term_cnt++.
    - If prod_done and term_cnt==NUM_TERMS-1: sum_out <= acc+prod_in; sum_valid<=1; mul_en<=0; term_cnt<=NUM_TERMS; go to HOLD.
    - start is ignored in ACCUM.
  - HOLD: sum_valid=1, sum_out frozen, mul_en=0.
    - sum_ready=1 and start=0 -> sum_valid<=0, go to IDLE.
    - sum_ready=1 and start=1 -> sum_valid<=0; restart as in IDLE (acc/cnt cleared, mul_en<=1), go to ACCUM. This is back-to-back operation.
    - sum_ready=0 -> hold indefinitely; start ignored.
- Latency:
  - First mul_en=1 one cycle after start is accepted.
  - sum_valid=1 one cycle after the final prod_done.
  - sum_valid falls one cycle after the handshake cycle (sum_valid & sum_ready).
- Arithmetic:
  - Unsigned.
  - ACC_WIDTH is sized so NUM_TERMS*(2^PROD_WIDTH-1) never overflows; no saturation logic.
  - sum_out keeps its last value after the handshake until the next result is written.
- prod_done outside ACCUM:
  - The product is not accumulated.
  - err_drop<=1, sticky until reset or the next accepted start.
- prod_done held high on consecutive cycles counts as one product per cycle. The multiplier contract guarantees a single pulse.
- NUM_TERMS=1: the first prod_done goes directly to HOLD with sum_out=prod_in.
- mul_en is low for at least one cycle between operations (HOLD/IDLE). This forces a multiplier restart.

Test Plan:
- PROD_WIDTH=10, NUM_TERMS=4: start; prod_done with 3, 5, 7, 9 at gaps of 32 cycles -> sum_out=24; sum_valid rises 1 cycle after the 4th pulse; term_cnt=4; mul_en falls in the same cycle sum_valid rises.
- Max values: four products of 1023 -> sum_out=4092 (12-bit), no wrap.
- Backpressure and back-to-back: hold sum_ready=0 for 50 cycles -> sum_out stable, mul_en=0. Then sum_ready=1 with start=1 -> next cycle sum_valid=0, mul_en=1, acc cleared. Next products 1, 1, 1, 1 -> sum_out=4.
- Stray done: prod_done with 100 in IDLE -> err_drop=1, acc unaffected. Next start clears err_drop. Products 2, 2, 2, 2 -> sum_out=8.
- Reset mid-op: rst asserted after 2 of 4 products (partial 15) -> outputs immediately 0, state IDLE. A fresh run of 1, 2, 3, 4 -> sum_out=10.
- NUM_TERMS=1 build: start, one product 777 -> sum_valid with sum_out=777 one cycle later.
